multi_dataflow_source_addrgen: RTL and testbench
================================================

MULTI_DATAFLOW_SOURCE_ADDRGEN -- requirements
Module: multi_dataflow_source_addrgen

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, TCDM byte-address width.
REQ-002 Parameter CNT_WIDTH, default 16, width of all length/size/count fields.
REQ-003 Port clk_i input 1: single clock, rising edge.
REQ-004 Port rst_ni input 1: reset, asynchronous, active-low.
REQ-005 Port test_mode_i input 1: test mode; no functional effect.
REQ-006 Port clear_i input 1: synchronous soft clear, active-high.
REQ-007 Port req_start_i input 1: start request from the control FSM.
REQ-008 Port ready_start_o output 1: block idle, start request acceptable.
REQ-009 Port done_o output 1: one-cycle pulse, transfer complete.
REQ-010 Ports base_addr_i, line_stride_i, feat_stride_i, step_i input ADDR_WIDTH: address configuration.
REQ-011 Ports trans_size_i, line_length_i, feat_length_i input CNT_WIDTH: total words, words per line, lines per feature.
REQ-012 Port addr_o output ADDR_WIDTH: generated byte address.
REQ-013 Port addr_valid_o output 1, addr_ready_i input 1: valid/ready address handshake to the TCDM request side.

Function
REQ-014 States IDLE and RUN only; ready_start_o = (state==IDLE).
REQ-015 IDLE & req_start_i: latch all config inputs; zero word_idx, line_idx, trans_cnt, word_offs, line_offs, feat_offs; go RUN if trans_size_i!=0.
REQ-016 IDLE & req_start_i & trans_size_i==0: stay IDLE, pulse done_o next cycle, issue no address.
REQ-017 req_start_i outside IDLE is ignored; latched config is never modified during RUN.
REQ-018 RUN: addr_valid_o=1; addr_o = base + feat_offs + line_offs + word_offs, modulo 2^ADDR_WIDTH, combinational from registers.
REQ-019 First addr_valid_o appears the cycle after start acceptance; throughput one address per cycle while addr_ready_i=1.
REQ-020 addr_o and counters hold stable while addr_valid_o=1 and addr_ready_i=0.
REQ-021 On handshake: word_idx++, word_offs+=step; trans_cnt++.
REQ-022 Line end (word_idx==line_length-1): word_idx=0, word_offs=0, line_idx++, line_offs+=line_stride.
REQ-023 Feature end (line end and line_idx==feat_length-1): line_idx=0, line_offs=0, feat_offs+=feat_stride.
REQ-024 line_length or feat_length of 0 is treated as 1.
REQ-025 Handshake with trans_cnt==trans_size-1: go IDLE, done_o=1 next cycle, ready_start_o=1 in that same cycle.
REQ-026 A start accepted in the done_o cycle is legal and begins a new transfer.

Reset
REQ-027 rst_ni low: state IDLE, all counters/offsets/latched config 0, done_o=0, addr_valid_o=0, ready_start_o=1.
REQ-028 clear_i high (priority over all other inputs): same values as reset on next edge; in-flight transfer abandoned, no done_o pulse.

Configuration
REQ-029 Macro MULTI_DATAFLOW_SRC_STALL_CNT_EN defined: adds output stall_cnt_o (CNT_WIDTH), counting cycles with addr_valid_o=1 and addr_ready_i=0, saturating at max, zeroed at start acceptance, reset and clear_i.
REQ-030 Macro undefined: port stall_cnt_o and its counter absent; all other behaviour identical.

Verification
REQ-031 base=0x1000, step=4, line_length=4, line_stride=0x40, feat_length=2, feat_stride=0x200, trans_size=10, ready always 1 -> addresses 0x1000,1004,1008,100C,1040,1044,1048,104C,1200,1204; done_o one cycle after last.
REQ-032 Same config, addr_ready_i low on cycles 2-4 -> addr_o held at 0x1008 through stall, same sequence; stall_cnt_o=3 when macro defined.
REQ-033 trans_size=0 -> no addr_valid_o; done_o pulses cycle after start; ready_start_o stays 1.
REQ-034 clear_i asserted after 3rd handshake of REQ-031 -> next cycle IDLE, addr_valid_o=0, no done_o; new start reissues 0x1000.
REQ-035 base=0xFFFF_FFF8, step=4, line_length=4, trans_size=4 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004 (wrap).
REQ-036 req_start_i held high throughout REQ-031 -> transfer not restarted mid-run; second transfer starts in done_o cycle.

Source files
------------

// File: rtl/multi_dataflow_source_addrgen_if.sv
// Address-generator bus: start/done control, address configuration and the
// valid/ready address handshake. Optional stall_cnt_o under MULTI_DATAFLOW_SRC_STALL_CNT_EN.
interface multi_dataflow_source_addrgen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  req_start_i;
  logic                  ready_start_o;
  logic                  done_o;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH-1:0] line_stride_i;
  logic [ADDR_WIDTH-1:0] feat_stride_i;
  logic [ADDR_WIDTH-1:0] step_i;
  logic [CNT_WIDTH-1:0]  trans_size_i;
  logic [CNT_WIDTH-1:0]  line_length_i;
  logic [CNT_WIDTH-1:0]  feat_length_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic                  addr_valid_o;
  logic                  addr_ready_i;
`ifdef MULTI_DATAFLOW_SRC_STALL_CNT_EN
  logic [CNT_WIDTH-1:0]  stall_cnt_o;

  modport slave (
    input  req_start_i, base_addr_i, line_stride_i, feat_stride_i, step_i,
           trans_size_i, line_length_i, feat_length_i, addr_ready_i,
    output ready_start_o, done_o, addr_o, addr_valid_o, stall_cnt_o
  );
  modport master (
    output req_start_i, base_addr_i, line_stride_i, feat_stride_i, step_i,
           trans_size_i, line_length_i, feat_length_i, addr_ready_i,
    input  ready_start_o, done_o, addr_o, addr_valid_o, stall_cnt_o
  );
`else
  modport slave (
    input  req_start_i, base_addr_i, line_stride_i, feat_stride_i, step_i,
           trans_size_i, line_length_i, feat_length_i, addr_ready_i,
    output ready_start_o, done_o, addr_o, addr_valid_o
  );
  modport master (
    output req_start_i, base_addr_i, line_stride_i, feat_stride_i, step_i,
           trans_size_i, line_length_i, feat_length_i, addr_ready_i,
    input  ready_start_o, done_o, addr_o, addr_valid_o
  );
`endif
endinterface

// File: rtl/multi_dataflow_source_addrgen.sv
// Three-level (word/line/feature) strided TCDM address generator for a dataflow source.
// Define MULTI_DATAFLOW_SRC_STALL_CNT_EN to add the saturating stall_cnt_o counter.
module multi_dataflow_source_addrgen #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk_i,
  input logic rst_ni,
  input logic test_mode_i,
  input logic clear_i,
  multi_dataflow_source_addrgen_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] line_stride;
    logic [ADDR_WIDTH-1:0] feat_stride;
    logic [ADDR_WIDTH-1:0] step;
    logic [CNT_WIDTH-1:0]  trans_size;
    logic [CNT_WIDTH-1:0]  line_len;
    logic [CNT_WIDTH-1:0]  feat_len;
  } cfg_t;

  state_e                state_q;
  cfg_t                  cfg_q;
  logic [CNT_WIDTH-1:0]  word_idx_q, line_idx_q, trans_cnt_q;
  logic [ADDR_WIDTH-1:0] word_offs_q, line_offs_q, feat_offs_q;
  logic                  done_q;
  logic                  hs, line_end, feat_end, last;
  logic                  unused_test_mode;

  assign unused_test_mode = test_mode_i;

  // Lengths are stored with 0 promoted to 1, so the end compares below never underflow.
  assign hs       = (state_q == RUN) && bus.addr_ready_i;
  assign line_end = (word_idx_q == cfg_q.line_len - CNT_ONE);
  assign feat_end = line_end && (line_idx_q == cfg_q.feat_len - CNT_ONE);
  assign last     = (trans_cnt_q == cfg_q.trans_size - CNT_ONE);

  assign bus.ready_start_o = (state_q == IDLE);
  assign bus.addr_valid_o  = (state_q == RUN);
  assign bus.done_o        = done_q;
  assign bus.addr_o        = cfg_q.base + feat_offs_q + line_offs_q + word_offs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      word_idx_q  <= '0;
      line_idx_q  <= '0;
      trans_cnt_q <= '0;
      word_offs_q <= '0;
      line_offs_q <= '0;
      feat_offs_q <= '0;
      done_q      <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      word_idx_q  <= '0;
      line_idx_q  <= '0;
      trans_cnt_q <= '0;
      word_offs_q <= '0;
      line_offs_q <= '0;
      feat_offs_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_start_i) begin
            cfg_q.base        <= bus.base_addr_i;
            cfg_q.line_stride <= bus.line_stride_i;
            cfg_q.feat_stride <= bus.feat_stride_i;
            cfg_q.step        <= bus.step_i;
            cfg_q.trans_size  <= bus.trans_size_i;
            cfg_q.line_len    <= (bus.line_length_i == '0) ? CNT_ONE : bus.line_length_i;
            cfg_q.feat_len    <= (bus.feat_length_i == '0) ? CNT_ONE : bus.feat_length_i;
            word_idx_q  <= '0;
            line_idx_q  <= '0;
            trans_cnt_q <= '0;
            word_offs_q <= '0;
            line_offs_q <= '0;
            feat_offs_q <= '0;
            // An empty transfer completes immediately without issuing anything.
            if (bus.trans_size_i == '0) done_q  <= 1'b1;
            else                        state_q <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            trans_cnt_q <= trans_cnt_q + CNT_ONE;
            if (line_end) begin
              word_idx_q  <= '0;
              word_offs_q <= '0;
              if (feat_end) begin
                line_idx_q  <= '0;
                line_offs_q <= '0;
                feat_offs_q <= feat_offs_q + cfg_q.feat_stride;
              end else begin
                line_idx_q  <= line_idx_q + CNT_ONE;
                line_offs_q <= line_offs_q + cfg_q.line_stride;
              end
            end else begin
              word_idx_q  <= word_idx_q + CNT_ONE;
              word_offs_q <= word_offs_q + cfg_q.step;
            end
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MULTI_DATAFLOW_SRC_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  assign bus.stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      stall_cnt_q <= '0;
    end else if ((state_q == IDLE) && bus.req_start_i) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN) && !bus.addr_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end
`endif
endmodule

// File: tb/tb_multi_dataflow_source_addrgen.sv
// Directed bench for multi_dataflow_source_addrgen: inputs change on the falling
// edge, outputs are checked on the falling edge with immediate assertions.
module tb_multi_dataflow_source_addrgen;
  localparam int AW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n, test_mode, clear;
  int   tests = 0;
  int   fails = 0;
  logic [AW-1:0] exp_a [0:15];

  always #5 clk = ~clk;

  multi_dataflow_source_addrgen_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  multi_dataflow_source_addrgen #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .clear_i     (clear),
    .bus         (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [AW-1:0] base, step, lstr, fstr,
                       input logic [CW-1:0] ts, ll, fl);
    @(negedge clk);
    bus.base_addr_i   = base;
    bus.step_i        = step;
    bus.line_stride_i = lstr;
    bus.feat_stride_i = fstr;
    bus.trans_size_i  = ts;
    bus.line_length_i = ll;
    bus.feat_length_i = fl;
    bus.req_start_i   = 1'b1;
  endtask

  // Walks one transfer from the cycle after acceptance; addr_ready_i is low
  // for cycles st_lo..st_hi (counted from the first valid cycle). Ends in the done cycle.
  task automatic run_xfer(input string tag, input int n, input int st_lo, input int st_hi,
                          input bit hold_start);
    int k = 0;
    int c = 0;
    while (k < n && c < 64) begin
      @(negedge clk);
      if (!hold_start) bus.req_start_i = 1'b0;
      check({tag, "_valid"}, 64'(bus.addr_valid_o), 64'd1);
      check({tag, "_addr"},  64'(bus.addr_o), 64'(exp_a[k]));
      check({tag, "_nodone"}, 64'(bus.done_o), 64'd0);
      bus.addr_ready_i = !(c >= st_lo && c <= st_hi);
      if (bus.addr_ready_i) k++;
      c++;
    end
    check({tag, "_count"}, 64'(k), 64'(n));
    @(negedge clk);
    bus.addr_ready_i = 1'b1;
    check({tag, "_done"},    64'(bus.done_o), 64'd1);
    check({tag, "_idle_v"},  64'(bus.addr_valid_o), 64'd0);
    check({tag, "_rdy_st"},  64'(bus.ready_start_o), 64'd1);
  endtask

  task automatic load_basic();
    exp_a[0] = 32'h1000; exp_a[1] = 32'h1004; exp_a[2] = 32'h1008; exp_a[3] = 32'h100C;
    exp_a[4] = 32'h1040; exp_a[5] = 32'h1044; exp_a[6] = 32'h1048; exp_a[7] = 32'h104C;
    exp_a[8] = 32'h1200; exp_a[9] = 32'h1204;
  endtask

  initial begin
    rst_n = 1'b0; test_mode = 1'b0; clear = 1'b0;
    bus.req_start_i = 1'b0; bus.addr_ready_i = 1'b1;
    bus.base_addr_i = '0; bus.step_i = '0; bus.line_stride_i = '0; bus.feat_stride_i = '0;
    bus.trans_size_i = '0; bus.line_length_i = '0; bus.feat_length_i = '0;
    #12;
    check("rst_rdy_st", 64'(bus.ready_start_o), 64'd1);
    check("rst_valid",  64'(bus.addr_valid_o), 64'd0);
    check("rst_done",   64'(bus.done_o), 64'd0);
    check("rst_addr",   64'(bus.addr_o), 64'd0);
`ifdef MULTI_DATAFLOW_SRC_STALL_CNT_EN
    check("rst_stall",  64'(bus.stall_cnt_o), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Basic three-level walk.
    load_basic();
    start(32'h1000, 32'h4, 32'h40, 32'h200, 16'd10, 16'd4, 16'd2);
    run_xfer("basic", 10, 99, 99, 1'b0);
    @(negedge clk);
    check("basic_pulse1", 64'(bus.done_o), 64'd0);

    // Back-pressure on cycles 2-4 holds 0x1008.
    start(32'h1000, 32'h4, 32'h40, 32'h200, 16'd10, 16'd4, 16'd2);
    run_xfer("stall", 10, 2, 4, 1'b0);
`ifdef MULTI_DATAFLOW_SRC_STALL_CNT_EN
    check("stall_cnt", 64'(bus.stall_cnt_o), 64'd3);
`endif

    // Empty transfer: done next cycle, nothing issued.
    start(32'h1000, 32'h4, 32'h40, 32'h200, 16'd0, 16'd4, 16'd2);
    @(negedge clk);
    bus.req_start_i = 1'b0;
    check("empty_done",   64'(bus.done_o), 64'd1);
    check("empty_valid",  64'(bus.addr_valid_o), 64'd0);
    check("empty_rdy_st", 64'(bus.ready_start_o), 64'd1);
    @(negedge clk);
    check("empty_pulse1", 64'(bus.done_o), 64'd0);
    check("empty_valid2", 64'(bus.addr_valid_o), 64'd0);

    // Clear after the third handshake abandons the transfer.
    start(32'h1000, 32'h4, 32'h40, 32'h200, 16'd10, 16'd4, 16'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_start_i = 1'b0;
      check("clr_addr", 64'(bus.addr_o), 64'(exp_a[i]));
    end
    @(negedge clk);
    check("clr_addr3", 64'(bus.addr_o), 64'h100C);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_valid",  64'(bus.addr_valid_o), 64'd0);
    check("clr_rdy_st", 64'(bus.ready_start_o), 64'd1);
    check("clr_done",   64'(bus.done_o), 64'd0);
    @(negedge clk);
    check("clr_done2",  64'(bus.done_o), 64'd0);
    start(32'h1000, 32'h4, 32'h40, 32'h200, 16'd10, 16'd4, 16'd2);
    run_xfer("reissue", 10, 99, 99, 1'b0);

    // Address wraps modulo 2^32.
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    start(32'hFFFF_FFF8, 32'h4, 32'h0, 32'h0, 16'd4, 16'd4, 16'd1);
    run_xfer("wrap", 4, 99, 99, 1'b0);

    // Zero line/feature lengths behave as 1: every word ends a feature.
    exp_a[0] = 32'h0100; exp_a[1] = 32'h1100; exp_a[2] = 32'h2100;
    start(32'h100, 32'h4, 32'h10, 32'h1000, 16'd3, 16'd0, 16'd0);
    run_xfer("len0", 3, 99, 99, 1'b0);

    // req_start held high: no mid-run restart; next transfer starts in the done cycle.
    load_basic();
    start(32'h1000, 32'h4, 32'h40, 32'h200, 16'd10, 16'd4, 16'd2);
    run_xfer("hold1", 10, 99, 99, 1'b1);
    run_xfer("hold2", 10, 99, 99, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
